// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract/accumulate pipeline.
// Optional build macro: ADDSUB_SATURATE_EN (clamp overflowing results).
package addsub_pkg;

  // Operation select carried alongside every operand pair.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  // True when an op writes the accumulator as it enters stage 2.
  function automatic logic op_writes_acc(input op_t op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/addsub_if.sv
// Producer/consumer bus for addsub_pipe.
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high; the sender holds its payload stable while valid is high
// and ready is low, and ready may depend combinationally on the other side.
// master = producer/consumer side, slave = the pipeline.
interface addsub_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  op_t              in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic [WIDTH-1:0] acc_value;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, acc_value
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, acc_value
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational arithmetic for one operation: ADD, SUB, ACC (acc + a), CLR.
// Everything is evaluated at WIDTH+1 bits so the carry falls out of the top bit.
// With ADDSUB_SATURATE_EN defined, overflowing ADD/SUB/ACC results clamp to
// the signed max/min; otherwise they wrap.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   wide_add;
  logic [WIDTH:0]   wide_sub;
  logic [WIDTH-1:0] wrap_sum;

  // Select the operand pair: ACC adds operand A onto the accumulator.
  always_comb begin
    x = a;
    y = b;
    if (op == OP_ACC) begin
      x = acc;
      y = a;
    end
  end

  assign wide_add = {1'b0, x} + {1'b0, y};
  assign wide_sub = {1'b0, x} - {1'b0, y};

  // Wrapped result and flags; SUB reports not-borrow as its carry.
  always_comb begin
    wrap_sum = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op)
      OP_ADD, OP_ACC: begin
        wrap_sum = wide_add[WIDTH-1:0];
        carry    = wide_add[WIDTH];
        ovf      = (x[WIDTH-1] == y[WIDTH-1]) && (wrap_sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        wrap_sum = wide_sub[WIDTH-1:0];
        carry    = ~wide_sub[WIDTH];
        ovf      = (x[WIDTH-1] != y[WIDTH-1]) && (wrap_sum[WIDTH-1] != x[WIDTH-1]);
      end
      default: begin
        wrap_sum = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
      end
    endcase
  end

`ifdef ADDSUB_SATURATE_EN
  // On overflow the true result has the sign of x (both ADD and SUB overflow
  // only when the result sign flips away from x), so clamp towards that sign.
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp overflowing results; non-overflowing results pass through.
  always_comb begin
    sum = wrap_sum;
    if (ovf) begin
      sum = x[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum = wrap_sum;
`endif

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/subtract/accumulate unit with valid/ready on both
// sides. S1 captures the operation, S2 holds the computed result and flags.
// The accumulator is written as an ACC/CLR op moves from S1 into S2, so a
// following ACC in S1 always sees the freshly updated value.
// enable low freezes every register and hides both handshakes.
// Optional build macro: ADDSUB_SATURATE_EN (handled inside addsub_core).
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  addsub_if.slave  bus
);

  // Stage 1: captured operation.
  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: registered result.
  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_carry;
  logic             s2_ovf;

  logic [WIDTH-1:0] acc_q;

  // Core outputs for the op currently in S1.
  logic [WIDTH-1:0] core_sum;
  logic             core_carry;
  logic             core_ovf;

  logic s2_free;
  logic s1_move;
  logic in_fire;

  assign s2_free  = !s2_valid || bus.out_ready;
  assign s1_move  = enable && s1_valid && s2_free;
  assign in_fire  = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = enable && (!s1_valid || s2_free);
  assign bus.out_valid = enable && s2_valid;
  assign bus.out_sum   = s2_sum;
  assign bus.out_carry = s2_carry;
  assign bus.out_ovf   = s2_ovf;
  assign bus.acc_value = acc_q;

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (s1_op),
    .a     (s1_a),
    .b     (s1_b),
    .acc   (acc_q),
    .sum   (core_sum),
    .carry (core_carry),
    .ovf   (core_ovf)
  );

  // Stage 1: load on input transfer, empty when its op moves on unreplaced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (enable) begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_op    <= bus.in_op;
        s1_a     <= bus.in_a;
        s1_b     <= bus.in_b;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: load the computed result, or empty after the consumer takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_carry <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (enable) begin
      if (s1_move) begin
        s2_valid <= 1'b1;
        s2_sum   <= core_sum;
        s2_carry <= core_carry;
        s2_ovf   <= core_ovf;
      end else if (s2_valid && bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Accumulator: ACC stores its (possibly clamped) sum, CLR stores zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (s1_move && op_writes_acc(s1_op)) begin
      acc_q <= core_sum;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32). A negedge monitor feeds
// every accepted op into an arithmetic reference model and compares each
// delivered result, its flags and the accumulator against the expected queue.
// Follows ADDSUB_SATURATE_EN when that macro is defined for the build.
module tb_addsub_pipe;
  import addsub_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  addsub_if #(.WIDTH(W)) bus ();

  addsub_pipe #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2*W+1:0] exp_q[$];   // {sum, carry, ovf, acc_after}
  logic [W-1:0]   m_acc = '0;
  logic           hold_pend = 1'b0;
  logic [W+1:0]   hold_val = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain signed/unsigned arithmetic on 64-bit integers.
  task automatic model_push(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] xv, yv, s, smax_v, smin_v;
    longint xs, ys, xu, yu, ts;
    logic c, v;
    smax_v = {1'b0, {(W-1){1'b1}}};
    smin_v = {1'b1, {(W-1){1'b0}}};
    if (op == OP_CLR) begin
      s = '0; c = 1'b0; v = 1'b0;
      m_acc = '0;
    end else begin
      xv = (op == OP_ACC) ? m_acc : a;
      yv = (op == OP_ACC) ? a : b;
      xs = longint'($signed(xv));
      ys = longint'($signed(yv));
      xu = longint'(xv);
      yu = longint'(yv);
      if (op == OP_SUB) begin
        ts = xs - ys;
        c  = (xu >= yu);
      end else begin
        ts = xs + ys;
        c  = ((xu + yu) >> W) != 0;
      end
      s = ts[W-1:0];
      v = (ts > SMAX) || (ts < SMIN);
`ifdef ADDSUB_SATURATE_EN
      if (v) s = (ts > 0) ? smax_v : smin_v;
`endif
      if (op == OP_ACC) m_acc = s;
    end
    exp_q.push_back({s, c, v, m_acc});
  endtask

  // Monitor: transfers are observed mid-cycle and commit on the next edge.
  always @(negedge clk) begin
    logic [2*W+1:0] e;
    if (!reset) begin
      exp_q.delete();
      m_acc     = '0;
      hold_pend = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (hold_pend)
          check("hold", {32'd0, bus.out_sum, bus.out_carry, bus.out_ovf}, {32'd0, hold_val});
        hold_pend = !bus.out_ready;
        hold_val  = {bus.out_sum, bus.out_carry, bus.out_ovf};
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sum",   64'(bus.out_sum),   64'(e[2*W+1:W+2]));
          check("carry", 64'(bus.out_carry), 64'(e[W+1]));
          check("ovf",   64'(bus.out_ovf),   64'(e[W]));
          check("acc",   64'(bus.acc_value), 64'(e[W-1:0]));
        end
      end
      if (bus.in_valid && bus.in_ready)
        model_push(bus.in_op, bus.in_a, bus.in_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return {{(W-1){1'b0}}, 1'b1};
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic took;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset for two cycles, then everything reads zero.
    repeat (2) tick();
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum",       64'(bus.out_sum),   64'd0);
    check("rst_carry",     64'(bus.out_carry), 64'd0);
    check("rst_ovf",       64'(bus.out_ovf),   64'd0);
    check("rst_acc",       64'(bus.acc_value), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Basic ADD with latency check: valid appears two cycles after issue.
    send(OP_ADD, 32'd5, 32'd7);
    @(negedge clk);
    check("lat_early", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_sum",   64'(bus.out_sum),   64'd12);
    tick();
    drain();

    // Flag corner cases, back to back.
    send(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1);
    send(OP_SUB, 32'd3, 32'd5);
    send(OP_SUB, 32'h8000_0000, 32'd1);
    drain();

    // Accumulator sequence with an interleaved ADD.
    send(OP_CLR, 32'd99, 32'd99);
    send(OP_ACC, 32'd10, 32'd0);
    send(OP_ACC, 32'd20, 32'd0);
    send(OP_ACC, 32'hFFFF_FFFB, 32'd0);
    send(OP_ADD, 32'd1, 32'd1);
    drain();
    check("acc_seq", 64'(bus.acc_value), 64'd25);

    // Backpressure: two ops fill the pipe, the third must wait.
    bus.out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2);
    send(OP_SUB, 32'd9, 32'd4);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ACC;
    bus.in_a     = 32'd5;
    bus.in_b     = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_accept();
    drain();

    // Freeze with two ops in flight.
    send(OP_ADD, 32'd100, 32'd200);
    send(OP_SUB, 32'd50, 32'd60);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("frz_out_valid", 64'(bus.out_valid), 64'd0);
      check("frz_in_ready",  64'(bus.in_ready),  64'd0);
      check("frz_acc",       64'(bus.acc_value), 64'(m_acc));
      tick();
    end
    enable = 1'b1;
    drain();

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send(OP_ACC, 32'd7, 32'd0);
    send(OP_ADD, 32'd1, 32'd2);
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_acc",   64'(bus.acc_value), 64'd0);
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send(OP_ACC, 32'd9, 32'd0);
    drain();
    check("acc_after_rst", 64'(bus.acc_value), 64'd9);

    // Randomized traffic with random backpressure and enable gaps.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      tick();
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_op    = op_t'($urandom_range(0, 3));
        bus.in_a     = rnd_val();
        bus.in_b     = rnd_val();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 9) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    enable        = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
